// File: rtl/mc_ctrl.sv
// Multi-cycle MIPS control sequencer: steps each instruction through FETCH/DECODE/EXEC/MEM/WB,
// drives the unified memory req/ready port and the datapath control fields.
module mc_ctrl #(
    parameter int unsigned CNT_W = 32
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic [5:0]       opcode,
    input  logic [5:0]       funct,
    input  logic             Zero,
    input  logic             mem_ready,
    output logic             mem_req,
    output logic             mem_we,
    output logic             mem_asel,
    output logic             IRWr,
    output logic             PCWr,
    output logic             RFWr,
    output logic [4:0]       ALUOp,
    output logic [2:0]       NPCOp,
    output logic             ASel,
    output logic             BSel,
    output logic [1:0]       EXTOp,
    output logic [1:0]       GPRSel,
    output logic [2:0]       WDSel,
    output logic             flush,
    output logic [2:0]       state,
    output logic [CNT_W-1:0] icnt
);
    localparam logic [4:0] ALUOp_NOP  = 5'd0,  ALUOp_ADD  = 5'd1,  ALUOp_SUB  = 5'd2,
                           ALUOp_AND  = 5'd3,  ALUOp_OR   = 5'd4,  ALUOp_XOR  = 5'd5,
                           ALUOp_NOR  = 5'd6,  ALUOp_SLT  = 5'd7,  ALUOp_SLTU = 5'd8,
                           ALUOp_LUI  = 5'd9,  ALUOp_SLL  = 5'd10, ALUOp_SRL  = 5'd11,
                           ALUOp_SRA  = 5'd12, ALUOp_ADDU = 5'd13, ALUOp_SUBU = 5'd14,
                           ALUOp_SLLV = 5'd15, ALUOp_SRLV = 5'd16, ALUOp_SRAV = 5'd17;
    localparam logic [2:0] NPC_PLUS4 = 3'd0, NPC_BRANCH = 3'd1, NPC_JUMP = 3'd2,
                           NPC_JR    = 3'd3, NPC_EXCEPT = 3'd4;
    localparam logic [1:0] EXT_ZERO = 2'd0, EXT_SIGNED = 2'd1;
    localparam logic [1:0] GPRSel_RD = 2'd0, GPRSel_RT = 2'd1, GPRSel_31 = 2'd2;
    localparam logic [2:0] WDSel_FromALU = 3'd0, WDSel_FromMEM = 3'd1, WDSel_FromPC = 3'd2;

    localparam logic [5:0] OP_R    = 6'b000000, OP_J     = 6'b000010, OP_JAL  = 6'b000011,
                           OP_BEQ  = 6'b000100, OP_ADDI  = 6'b001000, OP_ADDIU = 6'b001001,
                           OP_SLTI = 6'b001010, OP_SLTIU = 6'b001011, OP_ANDI = 6'b001100,
                           OP_ORI  = 6'b001101, OP_XORI  = 6'b001110, OP_LUI  = 6'b001111,
                           OP_LW   = 6'b100011, OP_SW    = 6'b101011;

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_EXCEPT = 3'd5
    } state_e;

    typedef enum logic [2:0] {C_R, C_I, C_LW, C_SW, C_BEQ, C_J, C_JAL, C_ILL} cls_e;

    state_e           r_state, w_state_nxt;
    logic [CNT_W-1:0] r_icnt;
    cls_e             w_cls;
    logic [4:0]       w_i_alu, w_r_alu;
    logic [1:0]       w_i_ext;
    logic             w_r_shamt, w_r_ok, w_r_jr;

    logic             w_mem_req, w_mem_we, w_mem_asel, w_IRWr, w_PCWr, w_RFWr;
    logic             w_ASel, w_BSel, w_flush;
    logic [4:0]       w_ALUOp;
    logic [2:0]       w_NPCOp, w_WDSel;
    logic [1:0]       w_EXTOp, w_GPRSel;

    always_comb begin
        w_cls   = C_ILL;
        w_i_alu = ALUOp_NOP;
        w_i_ext = EXT_ZERO;
        case (opcode)
            OP_R:     w_cls = C_R;
            OP_J:     w_cls = C_J;
            OP_JAL:   w_cls = C_JAL;
            OP_BEQ:   w_cls = C_BEQ;
            OP_LW:    w_cls = C_LW;
            OP_SW:    w_cls = C_SW;
            OP_ADDI:  begin w_cls = C_I; w_i_alu = ALUOp_ADD;  w_i_ext = EXT_SIGNED; end
            OP_ADDIU: begin w_cls = C_I; w_i_alu = ALUOp_ADDU; w_i_ext = EXT_SIGNED; end
            OP_SLTI:  begin w_cls = C_I; w_i_alu = ALUOp_SLT;  w_i_ext = EXT_SIGNED; end
            OP_SLTIU: begin w_cls = C_I; w_i_alu = ALUOp_SLTU; w_i_ext = EXT_SIGNED; end
            OP_ANDI:  begin w_cls = C_I; w_i_alu = ALUOp_AND;  end
            OP_ORI:   begin w_cls = C_I; w_i_alu = ALUOp_OR;   end
            OP_XORI:  begin w_cls = C_I; w_i_alu = ALUOp_XOR;  end
            OP_LUI:   begin w_cls = C_I; w_i_alu = ALUOp_LUI;  end
            default:  ;
        endcase
    end

    always_comb begin
        w_r_alu   = ALUOp_NOP;
        w_r_shamt = 1'b0;
        w_r_ok    = 1'b1;
        w_r_jr    = 1'b0;
        case (funct)
            6'b100000: w_r_alu = ALUOp_ADD;
            6'b100001: w_r_alu = ALUOp_ADDU;
            6'b100010: w_r_alu = ALUOp_SUB;
            6'b100011: w_r_alu = ALUOp_SUBU;
            6'b100100: w_r_alu = ALUOp_AND;
            6'b100101: w_r_alu = ALUOp_OR;
            6'b100110: w_r_alu = ALUOp_XOR;
            6'b100111: w_r_alu = ALUOp_NOR;
            6'b101010: w_r_alu = ALUOp_SLT;
            6'b101011: w_r_alu = ALUOp_SLTU;
            6'b000000: begin w_r_alu = ALUOp_SLL; w_r_shamt = 1'b1; end
            6'b000010: begin w_r_alu = ALUOp_SRL; w_r_shamt = 1'b1; end
            6'b000011: begin w_r_alu = ALUOp_SRA; w_r_shamt = 1'b1; end
            6'b000100: w_r_alu = ALUOp_SLLV;
            6'b000110: w_r_alu = ALUOp_SRLV;
            6'b000111: w_r_alu = ALUOp_SRAV;
            6'b001000: w_r_jr  = 1'b1;
            default:   w_r_ok  = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) r_state <= S_FETCH;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_mem_req   = 1'b0;
        w_mem_we    = 1'b0;
        w_mem_asel  = 1'b0;
        w_IRWr      = 1'b0;
        w_PCWr      = 1'b0;
        w_RFWr      = 1'b0;
        w_ALUOp     = ALUOp_NOP;
        w_NPCOp     = NPC_PLUS4;
        w_ASel      = 1'b0;
        w_BSel      = 1'b0;
        w_EXTOp     = EXT_ZERO;
        w_GPRSel    = GPRSel_RD;
        w_WDSel     = WDSel_FromALU;
        w_flush     = 1'b0;
        case (r_state)
            S_FETCH: begin
                w_mem_req = 1'b1;
                if (mem_ready) begin
                    w_IRWr      = 1'b1;
                    w_state_nxt = S_DECODE;
                end
            end
            S_DECODE: begin
                case (w_cls)
                    C_J: begin
                        w_PCWr      = 1'b1;
                        w_NPCOp     = NPC_JUMP;
                        w_state_nxt = S_FETCH;
                    end
                    C_JAL:   w_state_nxt = S_WB;
                    C_ILL:   w_state_nxt = S_EXCEPT;
                    default: w_state_nxt = S_EXEC;
                endcase
            end
            S_EXEC: begin
                case (w_cls)
                    C_R: begin
                        if (w_r_jr) begin
                            w_PCWr      = 1'b1;
                            w_NPCOp     = NPC_JR;
                            w_state_nxt = S_FETCH;
                        end else if (w_r_ok) begin
                            w_ALUOp     = w_r_alu;
                            w_ASel      = w_r_shamt;
                            w_state_nxt = S_WB;
                        end else begin
                            w_state_nxt = S_EXCEPT;
                        end
                    end
                    C_I: begin
                        w_ALUOp     = w_i_alu;
                        w_BSel      = 1'b1;
                        w_EXTOp     = w_i_ext;
                        w_state_nxt = S_WB;
                    end
                    C_LW, C_SW: begin
                        w_ALUOp     = ALUOp_ADD;
                        w_BSel      = 1'b1;
                        w_EXTOp     = EXT_SIGNED;
                        w_state_nxt = S_MEM;
                    end
                    C_BEQ: begin
                        w_ALUOp     = ALUOp_SUB;
                        w_PCWr      = 1'b1;
                        w_NPCOp     = Zero ? NPC_BRANCH : NPC_PLUS4;
                        w_state_nxt = S_FETCH;
                    end
                    C_JAL:   w_state_nxt = S_WB;
                    default: w_state_nxt = S_EXCEPT;
                endcase
            end
            S_MEM: begin
                // opcode is held stable, so req/we/asel cannot change while waiting
                w_mem_req  = 1'b1;
                w_mem_asel = 1'b1;
                w_mem_we   = (w_cls == C_SW);
                if (mem_ready) begin
                    if (w_cls == C_SW) begin
                        w_PCWr      = 1'b1;
                        w_NPCOp     = NPC_PLUS4;
                        w_state_nxt = S_FETCH;
                    end else begin
                        w_state_nxt = S_WB;
                    end
                end
            end
            S_WB: begin
                w_RFWr      = 1'b1;
                w_PCWr      = 1'b1;
                w_state_nxt = S_FETCH;
                case (w_cls)
                    C_R:     begin w_GPRSel = GPRSel_RD; w_WDSel = WDSel_FromALU; end
                    C_LW:    begin w_GPRSel = GPRSel_RT; w_WDSel = WDSel_FromMEM; end
                    C_JAL:   begin w_GPRSel = GPRSel_31; w_WDSel = WDSel_FromPC; w_NPCOp = NPC_JUMP; end
                    default: begin w_GPRSel = GPRSel_RT; w_WDSel = WDSel_FromALU; end
                endcase
            end
            S_EXCEPT: begin
                w_PCWr      = 1'b1;
                w_NPCOp     = NPC_EXCEPT;
                w_flush     = 1'b1;
                w_state_nxt = S_FETCH;
            end
            default: w_state_nxt = S_FETCH;
        endcase
    end

    // Outputs are gated by rstn so an asserted reset silences the memory port immediately.
    assign mem_req  = rstn & w_mem_req;
    assign mem_we   = rstn & w_mem_we;
    assign mem_asel = rstn & w_mem_asel;
    assign IRWr     = rstn & w_IRWr;
    assign PCWr     = rstn & w_PCWr;
    assign RFWr     = rstn & w_RFWr;
    assign ASel     = rstn & w_ASel;
    assign BSel     = rstn & w_BSel;
    assign flush    = rstn & w_flush;
    assign ALUOp    = rstn ? w_ALUOp  : '0;
    assign NPCOp    = rstn ? w_NPCOp  : '0;
    assign EXTOp    = rstn ? w_EXTOp  : '0;
    assign GPRSel   = rstn ? w_GPRSel : '0;
    assign WDSel    = rstn ? w_WDSel  : '0;
    assign state    = rstn ? r_state  : '0;
    assign icnt     = r_icnt;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)
            r_icnt <= '0;
        else if (PCWr && !flush)
            r_icnt <= r_icnt + CNT_W'(1);
    end

endmodule

// File: tb/tb_mc_ctrl.sv
// Directed table-driven bench for mc_ctrl: per-cycle input/expected-output rows,
// plus a hand-written retire-counter wrap sequence.
module tb_mc_ctrl;
    localparam int unsigned CW = 4;

    localparam logic [4:0] ALU_NOP = 5'd0, ALU_ADD = 5'd1, ALU_SUB = 5'd2, ALU_OR = 5'd4, ALU_SLL = 5'd10;
    localparam logic [2:0] NPC_PLUS4 = 3'd0, NPC_BRANCH = 3'd1, NPC_JUMP = 3'd2, NPC_JR = 3'd3, NPC_EXCEPT = 3'd4;
    localparam logic [1:0] EXT_ZERO = 2'd0, EXT_SIGNED = 2'd1;
    localparam logic [1:0] GPR_RD = 2'd0, GPR_RT = 2'd1, GPR_31 = 2'd2;
    localparam logic [2:0] WD_ALU = 3'd0, WD_MEM = 3'd1, WD_PC = 3'd2;
    localparam logic [2:0] S_F = 3'd0, S_D = 3'd1, S_E = 3'd2, S_M = 3'd3, S_W = 3'd4, S_X = 3'd5;
    localparam logic [5:0] OP_R = 6'b000000, OP_J = 6'b000010, OP_JAL = 6'b000011, OP_BEQ = 6'b000100,
                           OP_ORI = 6'b001101, OP_LW = 6'b100011, OP_SW = 6'b101011, OP_BAD = 6'b111111;
    localparam logic [5:0] F_ADD = 6'b100000, F_SLL = 6'b000000, F_JR = 6'b001000, F_BAD = 6'b111111;

    logic          clk = 1'b0;
    logic          rstn = 1'b0;
    logic [5:0]    opcode = '0, funct = '0;
    logic          Zero = 1'b0, mem_ready = 1'b1;
    logic          mem_req, mem_we, mem_asel, IRWr, PCWr, RFWr, ASel, BSel, flush;
    logic [4:0]    ALUOp;
    logic [2:0]    NPCOp, WDSel, state;
    logic [1:0]    EXTOp, GPRSel;
    logic [CW-1:0] icnt;

    always #5 clk = ~clk;

    mc_ctrl #(.CNT_W(CW)) dut (
        .clk(clk), .rstn(rstn), .opcode(opcode), .funct(funct), .Zero(Zero), .mem_ready(mem_ready),
        .mem_req(mem_req), .mem_we(mem_we), .mem_asel(mem_asel), .IRWr(IRWr), .PCWr(PCWr), .RFWr(RFWr),
        .ALUOp(ALUOp), .NPCOp(NPCOp), .ASel(ASel), .BSel(BSel), .EXTOp(EXTOp), .GPRSel(GPRSel),
        .WDSel(WDSel), .flush(flush), .state(state), .icnt(icnt)
    );

    typedef struct packed {
        logic [2:0]  state;
        logic        mem_req, mem_we, mem_asel, IRWr, PCWr, RFWr;
        logic [4:0]  ALUOp;
        logic [2:0]  NPCOp;
        logic        ASel, BSel;
        logic [1:0]  EXTOp, GPRSel;
        logic [2:0]  WDSel;
        logic        flush;
        logic [31:0] icnt;
    } out_t;

    typedef struct {
        string      name;
        logic       rstn;
        logic [5:0] op;
        logic [5:0] fn;
        logic       zero;
        logic       rdy;
        out_t       exp;
    } vec_t;

    vec_t        vecs[$];
    int unsigned n_vec = 0;
    int unsigned n_bad = 0;

    function automatic out_t base(input logic [2:0] st, input int ic);
        out_t e = '0;
        e.state = st;
        e.icnt  = 32'(ic);
        return e;
    endfunction

    function automatic out_t fet(input int ic);
        out_t e = base(S_F, ic);
        e.mem_req = 1'b1;
        e.IRWr    = 1'b1;
        return e;
    endfunction

    task automatic add(input string n, input logic rs, input logic [5:0] op, input logic [5:0] fn,
                       input logic zr, input logic rdy, input out_t ex);
        vec_t v;
        v.name = n; v.rstn = rs; v.op = op; v.fn = fn; v.zero = zr; v.rdy = rdy; v.exp = ex;
        vecs.push_back(v);
    endtask

    function automatic out_t actual();
        out_t a;
        a.state = state; a.mem_req = mem_req; a.mem_we = mem_we; a.mem_asel = mem_asel;
        a.IRWr = IRWr; a.PCWr = PCWr; a.RFWr = RFWr; a.ALUOp = ALUOp; a.NPCOp = NPCOp;
        a.ASel = ASel; a.BSel = BSel; a.EXTOp = EXTOp; a.GPRSel = GPRSel; a.WDSel = WDSel;
        a.flush = flush; a.icnt = 32'(icnt);
        return a;
    endfunction

    function automatic string fmt(input out_t o);
        return $sformatf("st=%0d req=%b we=%b as=%b ir=%b pc=%b rf=%b alu=%0d npc=%0d a=%b b=%b ext=%0d gpr=%0d wd=%0d fl=%b icnt=%0d",
                         o.state, o.mem_req, o.mem_we, o.mem_asel, o.IRWr, o.PCWr, o.RFWr, o.ALUOp, o.NPCOp,
                         o.ASel, o.BSel, o.EXTOp, o.GPRSel, o.WDSel, o.flush, o.icnt);
    endfunction

    task automatic wait_pcwr(output bit ok);
        ok = 1'b0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            #1;
            if (PCWr === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    initial begin
        out_t e;
        out_t a;

        for (int i = 0; i < 3; i++) add("reset", 1'b0, OP_R, F_ADD, 1'b0, 1'b1, base(S_F, 0));

        add("add.fetch", 1'b1, OP_R, F_ADD, 1'b0, 1'b1, fet(0));
        add("add.decode", 1'b1, OP_R, F_ADD, 1'b0, 1'b1, base(S_D, 0));
        e = base(S_E, 0); e.ALUOp = ALU_ADD;
        add("add.exec", 1'b1, OP_R, F_ADD, 1'b0, 1'b1, e);
        e = base(S_W, 0); e.RFWr = 1'b1; e.PCWr = 1'b1; e.GPRSel = GPR_RD; e.WDSel = WD_ALU; e.NPCOp = NPC_PLUS4;
        add("add.wb", 1'b1, OP_R, F_ADD, 1'b0, 1'b1, e);

        add("lw.fetch", 1'b1, OP_LW, 6'd0, 1'b0, 1'b1, fet(1));
        add("lw.decode", 1'b1, OP_LW, 6'd0, 1'b0, 1'b1, base(S_D, 1));
        e = base(S_E, 1); e.ALUOp = ALU_ADD; e.BSel = 1'b1; e.EXTOp = EXT_SIGNED;
        add("lw.exec", 1'b1, OP_LW, 6'd0, 1'b0, 1'b1, e);
        e = base(S_M, 1); e.mem_req = 1'b1; e.mem_asel = 1'b1;
        add("lw.mem.wait0", 1'b1, OP_LW, 6'd0, 1'b0, 1'b0, e);
        add("lw.mem.wait1", 1'b1, OP_LW, 6'd0, 1'b0, 1'b0, e);
        add("lw.mem.done", 1'b1, OP_LW, 6'd0, 1'b0, 1'b1, e);
        e = base(S_W, 1); e.RFWr = 1'b1; e.PCWr = 1'b1; e.GPRSel = GPR_RT; e.WDSel = WD_MEM;
        add("lw.wb", 1'b1, OP_LW, 6'd0, 1'b0, 1'b1, e);

        add("beq1.fetch", 1'b1, OP_BEQ, 6'd0, 1'b1, 1'b1, fet(2));
        add("beq1.decode", 1'b1, OP_BEQ, 6'd0, 1'b1, 1'b1, base(S_D, 2));
        e = base(S_E, 2); e.ALUOp = ALU_SUB; e.PCWr = 1'b1; e.NPCOp = NPC_BRANCH;
        add("beq1.exec", 1'b1, OP_BEQ, 6'd0, 1'b1, 1'b1, e);

        e = fet(3); e.IRWr = 1'b0;
        add("beq0.fetch.wait", 1'b1, OP_BEQ, 6'd0, 1'b0, 1'b0, e);
        add("beq0.fetch", 1'b1, OP_BEQ, 6'd0, 1'b0, 1'b1, fet(3));
        add("beq0.decode", 1'b1, OP_BEQ, 6'd0, 1'b0, 1'b1, base(S_D, 3));
        e = base(S_E, 3); e.ALUOp = ALU_SUB; e.PCWr = 1'b1; e.NPCOp = NPC_PLUS4;
        add("beq0.exec", 1'b1, OP_BEQ, 6'd0, 1'b0, 1'b1, e);

        add("ill.fetch", 1'b1, OP_BAD, 6'd0, 1'b0, 1'b1, fet(4));
        add("ill.decode", 1'b1, OP_BAD, 6'd0, 1'b0, 1'b1, base(S_D, 4));
        e = base(S_X, 4); e.PCWr = 1'b1; e.NPCOp = NPC_EXCEPT; e.flush = 1'b1;
        add("ill.except", 1'b1, OP_BAD, 6'd0, 1'b0, 1'b1, e);

        add("j.fetch", 1'b1, OP_J, 6'd0, 1'b0, 1'b1, fet(4));
        e = base(S_D, 4); e.PCWr = 1'b1; e.NPCOp = NPC_JUMP;
        add("j.decode", 1'b1, OP_J, 6'd0, 1'b0, 1'b1, e);

        add("jal.fetch", 1'b1, OP_JAL, 6'd0, 1'b0, 1'b1, fet(5));
        add("jal.decode", 1'b1, OP_JAL, 6'd0, 1'b0, 1'b1, base(S_D, 5));
        e = base(S_W, 5); e.RFWr = 1'b1; e.PCWr = 1'b1; e.GPRSel = GPR_31; e.WDSel = WD_PC; e.NPCOp = NPC_JUMP;
        add("jal.wb", 1'b1, OP_JAL, 6'd0, 1'b0, 1'b1, e);

        add("ori.fetch", 1'b1, OP_ORI, 6'd0, 1'b0, 1'b1, fet(6));
        add("ori.decode", 1'b1, OP_ORI, 6'd0, 1'b0, 1'b1, base(S_D, 6));
        e = base(S_E, 6); e.ALUOp = ALU_OR; e.BSel = 1'b1; e.EXTOp = EXT_ZERO;
        add("ori.exec", 1'b1, OP_ORI, 6'd0, 1'b0, 1'b1, e);
        e = base(S_W, 6); e.RFWr = 1'b1; e.PCWr = 1'b1; e.GPRSel = GPR_RT; e.WDSel = WD_ALU;
        add("ori.wb", 1'b1, OP_ORI, 6'd0, 1'b0, 1'b1, e);

        add("sll.fetch", 1'b1, OP_R, F_SLL, 1'b0, 1'b1, fet(7));
        add("sll.decode", 1'b1, OP_R, F_SLL, 1'b0, 1'b1, base(S_D, 7));
        e = base(S_E, 7); e.ALUOp = ALU_SLL; e.ASel = 1'b1;
        add("sll.exec", 1'b1, OP_R, F_SLL, 1'b0, 1'b1, e);
        e = base(S_W, 7); e.RFWr = 1'b1; e.PCWr = 1'b1; e.GPRSel = GPR_RD; e.WDSel = WD_ALU;
        add("sll.wb", 1'b1, OP_R, F_SLL, 1'b0, 1'b1, e);

        add("jr.fetch", 1'b1, OP_R, F_JR, 1'b0, 1'b1, fet(8));
        add("jr.decode", 1'b1, OP_R, F_JR, 1'b0, 1'b1, base(S_D, 8));
        e = base(S_E, 8); e.PCWr = 1'b1; e.NPCOp = NPC_JR;
        add("jr.exec", 1'b1, OP_R, F_JR, 1'b0, 1'b1, e);

        add("badfn.fetch", 1'b1, OP_R, F_BAD, 1'b0, 1'b1, fet(9));
        add("badfn.decode", 1'b1, OP_R, F_BAD, 1'b0, 1'b1, base(S_D, 9));
        e = base(S_E, 9); e.ALUOp = ALU_NOP;
        add("badfn.exec", 1'b1, OP_R, F_BAD, 1'b0, 1'b1, e);
        e = base(S_X, 9); e.PCWr = 1'b1; e.NPCOp = NPC_EXCEPT; e.flush = 1'b1;
        add("badfn.except", 1'b1, OP_R, F_BAD, 1'b0, 1'b1, e);

        add("sw.fetch", 1'b1, OP_SW, 6'd0, 1'b0, 1'b1, fet(9));
        add("sw.decode", 1'b1, OP_SW, 6'd0, 1'b0, 1'b1, base(S_D, 9));
        e = base(S_E, 9); e.ALUOp = ALU_ADD; e.BSel = 1'b1; e.EXTOp = EXT_SIGNED;
        add("sw.exec", 1'b1, OP_SW, 6'd0, 1'b0, 1'b1, e);
        e = base(S_M, 9); e.mem_req = 1'b1; e.mem_we = 1'b1; e.mem_asel = 1'b1; e.PCWr = 1'b1; e.NPCOp = NPC_PLUS4;
        add("sw.mem", 1'b1, OP_SW, 6'd0, 1'b0, 1'b1, e);

        add("swab.fetch", 1'b1, OP_SW, 6'd0, 1'b0, 1'b1, fet(10));
        add("swab.decode", 1'b1, OP_SW, 6'd0, 1'b0, 1'b1, base(S_D, 10));
        e = base(S_E, 10); e.ALUOp = ALU_ADD; e.BSel = 1'b1; e.EXTOp = EXT_SIGNED;
        add("swab.exec", 1'b1, OP_SW, 6'd0, 1'b0, 1'b1, e);
        e = base(S_M, 10); e.mem_req = 1'b1; e.mem_we = 1'b1; e.mem_asel = 1'b1;
        add("swab.mem.wait", 1'b1, OP_SW, 6'd0, 1'b0, 1'b0, e);
        add("swab.rst0", 1'b0, OP_SW, 6'd0, 1'b0, 1'b0, base(S_F, 0));
        add("swab.rst1", 1'b0, OP_SW, 6'd0, 1'b0, 1'b1, base(S_F, 0));
        e = fet(0); e.IRWr = 1'b0;
        add("swab.release", 1'b1, OP_SW, 6'd0, 1'b0, 1'b0, e);

        foreach (vecs[i]) begin
            @(negedge clk);
            rstn      = vecs[i].rstn;
            opcode    = vecs[i].op;
            funct     = vecs[i].fn;
            Zero      = vecs[i].zero;
            mem_ready = vecs[i].rdy;
            #1;
            a = actual();
            n_vec++;
            if (a !== vecs[i].exp) begin
                n_bad++;
                $display("FAIL %s: got {%s} want {%s}", vecs[i].name, fmt(a), fmt(vecs[i].exp));
            end
        end

        // Back-to-back jumps: each retires once, the counter wraps after 2**CW instructions.
        @(negedge clk);
        rstn = 1'b0; opcode = OP_J; funct = '0; Zero = 1'b0; mem_ready = 1'b1;
        repeat (2) @(negedge clk);
        rstn = 1'b1;
        for (int k = 1; k <= 16; k++) begin
            bit ok;
            wait_pcwr(ok);
            if (!ok) begin
                n_vec++;
                n_bad++;
                $display("FAIL wrap.j%0d: got no PCWr within 8 cycles, want PCWr=1", k);
                break;
            end
            @(negedge clk);
            #1;
            n_vec++;
            if (32'(icnt) !== 32'(k % (1 << CW))) begin
                n_bad++;
                $display("FAIL wrap.icnt%0d: got %0d want %0d", k, icnt, k % (1 << CW));
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
